// File: rtl/hkspi_xfer_pkg.sv
// Shared types and constants for the housekeeping SPI-to-register-bus transfer bridge.
package hkspi_xfer_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TMO_CNT_W = 8;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Read data returned to the SPI side when the register bus never acknowledges
  localparam logic [DATA_W-1:0] TMO_RD_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } xfer_state_e;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_req_t;

endpackage

// File: rtl/hkspi_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous level, reset to 0.
module hkspi_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/housekeeping_spi_xfer.sv
// Toggle-handshake bridge from the housekeeping SPI slave onto the register bus.
// Optional bus timeout enabled by defining HKSPI_XFER_TIMEOUT_EN.
module housekeeping_spi_xfer
  import hkspi_xfer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              spi_req_tgl,
  input  logic              spi_rnw,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack_tgl,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              xfer_busy,
  output logic              xfer_err,
  input  logic              err_clr
);

  xfer_state_e       state_q, state_d;
  xfer_req_t         req_q, req_d;
  logic              req_s;
  logic              req_seen_q, req_seen_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q;

  hkspi_sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .d     (spi_req_tgl),
    .q     (req_s)
  );

`ifdef HKSPI_XFER_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_q == TMO_CNT_W'(TIMEOUT_CYCLES));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    rdata_d    = rdata_q;
`ifdef HKSPI_XFER_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
    if (err_clr) err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Compare against the last accepted toggle so requests arriving while busy are kept
        if (req_s != req_seen_q) begin
          req_d.rnw   = spi_rnw;
          req_d.addr  = spi_addr;
          req_d.wdata = spi_wdata;
          req_seen_d  = req_s;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reg_ack) begin
          if (req_q.rnw) rdata_d = reg_rdata;
          state_d = ST_DONE;
        end
`ifdef HKSPI_XFER_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d = 1'b1;
          if (req_q.rnw) rdata_d = TMO_RD_FILL;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        ack_d   = req_seen_q;
`ifdef HKSPI_XFER_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
`ifdef HKSPI_XFER_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= (state_d != ST_IDLE);
`ifdef HKSPI_XFER_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  // Strobes are plain decodes of the state register
  assign reg_we      = (state_q == ST_ISSUE) && !req_q.rnw;
  assign reg_re      = (state_q == ST_ISSUE) &&  req_q.rnw;
  assign reg_addr    = req_q.addr;
  assign reg_wdata   = req_q.wdata;
  assign spi_rdata   = rdata_q;
  assign spi_ack_tgl = ack_q;
  assign xfer_busy   = busy_q;
`ifdef HKSPI_XFER_TIMEOUT_EN
  assign xfer_err    = err_q;
`else
  assign xfer_err    = 1'b0;
`endif

endmodule

// File: tb/tb_housekeeping_spi_xfer.sv
// Randomized self-checking bench for housekeeping_spi_xfer with a register-bank responder.
// Timeout scenarios run only when HKSPI_XFER_TIMEOUT_EN is defined.
module tb_housekeeping_spi_xfer;

  localparam int SYNC   = 2;
  localparam int TMO    = 8;
  localparam int NO_ACK = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_req_tgl, spi_rnw, spi_ack_tgl;
  logic [7:0] spi_addr, spi_wdata, spi_rdata;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, reg_ack;
  logic       xfer_busy, xfer_err, err_clr;

  always #5 clk = ~clk;

  housekeeping_spi_xfer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .spi_req_tgl (spi_req_tgl),
    .spi_rnw     (spi_rnw),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_ack_tgl (spi_ack_tgl),
    .spi_rdata   (spi_rdata),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .xfer_busy   (xfer_busy),
    .xfer_err    (xfer_err),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         len;
    int         start;
  } pulse_t;

  pulse_t     pq[$];
  pulse_t     cur;
  bit         in_pulse = 0;
  int         cyc = 0;
  int         ack_flips = 0;
  logic       prev_ack = 1'b0;
  int         ack_cnt = 0;
  int         ack_dly = 0;
  logic [7:0] bank  [256];
  logic [7:0] model [256];
  logic [7:0] last_rd;
  logic       tgl;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Register-bank responder and strobe monitor, sampling 1 time unit after each edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (spi_ack_tgl !== prev_ack) ack_flips++;
    prev_ack = spi_ack_tgl;
    if (reg_we === 1'b1 || reg_re === 1'b1) begin
      if (!in_pulse) begin
        in_pulse  = 1;
        cur.we    = reg_we;
        cur.re    = reg_re;
        cur.addr  = reg_addr;
        cur.wdata = reg_wdata;
        cur.len   = 0;
        cur.start = cyc;
      end
      cur.len++;
      if (ack_cnt == ack_dly) begin
        reg_ack   = 1'b1;
        reg_rdata = bank[reg_addr];
        if (reg_we) bank[reg_addr] = reg_wdata;
        ack_cnt   = 0;
      end else begin
        reg_ack   = 1'b0;
        reg_rdata = 8'($urandom);
        ack_cnt++;
      end
    end else begin
      if (in_pulse) begin
        pq.push_back(cur);
        in_pulse = 0;
      end
      reg_ack   = 1'b0;
      reg_rdata = 8'($urandom);
      ack_cnt   = 0;
    end
  end

  // One SPI request; tmo=1 means the bus never answers and the timeout must end it
  task automatic run_xfer(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                          input int dly, input bit tmo);
    pulse_t p;
    int n, nb, eff;
    eff     = tmo ? TMO : dly;
    ack_dly = tmo ? NO_ACK : dly;
    pq.delete();
    spi_rnw = rnw; spi_addr = addr; spi_wdata = wdata;
    tgl = ~tgl; spi_req_tgl = tgl;
    n = 0; nb = 0;
    do begin
      @(posedge clk); #2;
      n++;
      if (xfer_busy === 1'b1) nb++;
    end while (spi_ack_tgl !== tgl && n < 300);
    chk("ack_latency", n - 1, SYNC + 2 + eff);
    chk("busy_cycles", nb, eff + 2);
    chk("pulse_count", pq.size(), 1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      chk("strobe_we", p.we, !rnw);
      chk("strobe_re", p.re, rnw);
      chk("strobe_addr", p.addr, addr);
      if (!rnw) chk("strobe_wdata", p.wdata, wdata);
      chk("strobe_len", p.len, eff + 1);
    end
    if (rnw) last_rd = tmo ? 8'hFF : model[addr];
    else if (!tmo) model[addr] = wdata;
    chk("spi_rdata", spi_rdata, last_rd);
    chk("busy_idle", xfer_busy, 0);
    chk("addr_hold", reg_addr, addr);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack", spi_ack_tgl, 0);
    chk("rst_rdata", spi_rdata, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_busy", xfer_busy, 0);
    chk("rst_err", xfer_err, 0);
  endtask

  initial begin
    int n;
    spi_req_tgl = 0; tgl = 0; spi_rnw = 0; spi_addr = 0; spi_wdata = 0;
    err_clr = 0; reg_ack = 0; reg_rdata = 0; last_rd = 8'h00;
    for (int i = 0; i < 256; i++) begin
      bank[i]  = 8'($urandom);
      model[i] = bank[i];
    end
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed write, read with late ack, and ack landing on the timeout-limit cycle
    run_xfer(1'b0, 8'h0C, 8'hA5, 0, 0);
    chk("wdata_hold", reg_wdata, 8'hA5);
    bank[8'h03] = 8'h10; model[8'h03] = 8'h10;
    run_xfer(1'b1, 8'h03, 8'h00, 5, 0);
    run_xfer(1'b1, 8'h40, 8'h00, TMO, 0);
    chk("err_limit_ack", xfer_err, 0);

    // Second toggle flip while the first request is still busy
    ack_dly = 0; ack_flips = 0; pq.delete();
    spi_rnw = 1'b0; spi_addr = 8'h21; spi_wdata = 8'h5A;
    tgl = ~tgl; spi_req_tgl = tgl;
    n = 0;
    while (xfer_busy !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    tgl = ~tgl; spi_req_tgl = tgl;
    n = 0;
    while (!(ack_flips == 2 && spi_ack_tgl === tgl) && n < 60) begin @(posedge clk); #2; n++; end
    chk("b2b_ack_flips", ack_flips, 2);
    chk("b2b_ack_final", spi_ack_tgl, tgl);
    chk("b2b_pulses", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("b2b_gap", pq[1].start - (pq[0].start + pq[0].len - 1), 3);
      chk("b2b_addr", pq[1].addr, 8'h21);
      chk("b2b_we", pq[1].we, 1);
    end
    model[8'h21] = 8'h5A;

`ifdef HKSPI_XFER_TIMEOUT_EN
    run_xfer(1'b1, 8'h77, 8'h00, 0, 1);
    chk("tmo_err_set", xfer_err, 1);
    run_xfer(1'b0, 8'h55, 8'h66, 0, 1);
    run_xfer(1'b0, 8'h12, 8'h34, 1, 0);
    chk("tmo_err_sticky", xfer_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    chk("tmo_err_clr", xfer_err, 0);
`endif

    // Reset pulse while a read strobe is outstanding
    ack_dly = NO_ACK;
    spi_rnw = 1'b1; spi_addr = 8'h66;
    tgl = ~tgl; spi_req_tgl = tgl;
    n = 0;
    while (reg_re !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    chk("pre_reset_strobe", reg_re, 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0; spi_req_tgl = 1'b0; tgl = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("post_reset_no_ack", spi_ack_tgl, 0);
    chk("post_reset_idle", reg_re, 0);
    last_rd = 8'h00;
    run_xfer(1'b1, 8'h0C, 8'h00, 2, 0);

    // Randomized traffic
    for (int i = 0; i < 24; i++)
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 6)), 0);

    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    chk("err_final", xfer_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/housekeeping_spi_xfer.md
# housekeeping_spi_xfer

Clock-domain bridge that sits directly downstream of the housekeeping SPI slave. It accepts one register transaction at a time from the SPI side over a toggle request/acknowledge handshake, synchronizes it into the `wb_clk_i` domain, and executes it as a single read or write on the housekeeping register bus. It then returns read data and an acknowledge toggle to the SPI side. An optional bus timeout keeps a hung register bus from stalling the SPI engine.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `spi_req_tgl`; legal values are 2 to 4.
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit in ISSUE; legal values are 1 to 255; 8-bit counter.

Ports:
- `wb_clk_i` in 1: the single clock; all state is on the rising edge.
- `wb_rstn_i` in 1: reset, asynchronous and active-low.
- `spi_req_tgl` in 1: request toggle, asynchronous to `wb_clk_i`. Each level change is one new request.
- `spi_rnw` in 1: 1 = read, 0 = write. Stable from the toggle change until the matching `spi_ack_tgl` change.
- `spi_addr` in 8: register address. Same stability rule as `spi_rnw`.
- `spi_wdata` in 8: write data. Same stability rule as `spi_rnw`.
- `spi_ack_tgl` out 1: acknowledge toggle. It changes once per completed request.
- `spi_rdata` out 8: read data. Valid and stable whenever `spi_ack_tgl` equals the last request toggle.
- `reg_addr` out 8: register bus address.
- `reg_wdata` out 8: register bus write data.
- `reg_we` out 1: write strobe; a level held until `reg_ack`.
- `reg_re` out 1: read strobe; a level held until `reg_ack`.
- `reg_rdata` in 8: register bus read data. Valid in the cycle where `reg_ack` = 1.
- `reg_ack` in 1: single-cycle completion from the register bank.
- `xfer_busy` out 1: high whenever state ≠ IDLE.
- `xfer_err` out 1: sticky timeout flag.
- `err_clr` in 1: synchronous clear for `xfer_err`.

## Operation
- Synchronizer: `spi_req_tgl` passes through `SYNC_STAGES` flops to give `req_s`. Register `req_seen` holds the last accepted toggle value.
- State IDLE:
  - If `req_s != req_seen`: latch `spi_rnw`, `spi_addr` and `spi_wdata` into the `reg_*` registers, set `req_seen <= req_s`, go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - Drive `reg_we = !rnw` or `reg_re = rnw`.
  - On `reg_ack`: if read, capture `reg_rdata` into `spi_rdata`; go to DONE.
  - Otherwise increment `tmo_cnt`.
- State DONE: set `spi_ack_tgl <= req_seen`, clear `tmo_cnt`, go to IDLE.
- The strobes are combinational decodes of state and `rnw`; both are 0 outside ISSUE.
- `reg_addr` and `reg_wdata` hold their last latched values while in IDLE.
- A toggle change that arrives while state ≠ IDLE is not lost. It is accepted on the first IDLE cycle because the comparison is against `req_seen`.
- A `reg_ack` seen outside ISSUE is ignored.
- `xfer_err`:
  - `err_clr` clears it.
  - If a timeout set and `err_clr` occur in the same cycle, the set wins.
- SPI-side requirement: the SPI side's toggle resets to 0 together with `wb_rstn_i`.
- Reset values:
  - State = IDLE.
  - Synchronizer flops, `req_seen` and `spi_ack_tgl` = 0.
  - `spi_rdata`, `reg_addr` and `reg_wdata` = 8'h00.
  - `reg_we`, `reg_re`, `xfer_busy` and `xfer_err` = 0.
  - `tmo_cnt` = 0.
- Reset asserted mid-transaction aborts it immediately. No acknowledge toggle is produced.

## Timing
- Let edge E be the first `wb_clk_i` edge that samples the new `spi_req_tgl` level.
  - `req_s` changes after edge E+`SYNC_STAGES`-1.
  - State becomes ISSUE and a strobe rises after edge E+`SYNC_STAGES`.
- If `reg_ack` is high in the first ISSUE cycle, that strobe lasts exactly 1 cycle.
- DONE occupies 1 cycle. `spi_ack_tgl` flips at the edge leaving DONE.
- Minimum request-to-acknowledge latency is `SYNC_STAGES`+2 edges after E.
- Back-to-back requests: the next request can be accepted on the first IDLE cycle.
- `xfer_busy` rises with ISSUE and falls on return to IDLE.

## Configuration
- Macro: `HKSPI_XFER_TIMEOUT_EN`.
- Defined:
  - In ISSUE, if `tmo_cnt` == `TIMEOUT_CYCLES` with no `reg_ack`: drop the strobe, set `xfer_err`, set `spi_rdata <= 8'hFF` if read (a write leaves `spi_rdata` unchanged), go to DONE.
  - The acknowledge toggle is still produced.
- Undefined:
  - ISSUE waits indefinitely.
  - `tmo_cnt` is not built.
  - `xfer_err` is tied to 0.
  - `err_clr` is ignored.

## Structure
- Package `hkspi_xfer_pkg` holds:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, DONE=2'd2.
  - The timeout read fill value 8'hFF.
  - Default parameter values.
- Sub-module `hkspi_sync_ff`: a parameterized N-stage synchronizer with async active-low reset. It is instantiated once for `spi_req_tgl`.

## Test plan
- Write: `spi_addr`=8'h0C, `spi_wdata`=8'hA5, toggle 0→1, bench acks on the 1st ISSUE cycle → `reg_we` high for 1 cycle with `reg_addr`=8'h0C and `reg_wdata`=8'hA5; `spi_ack_tgl`=1 at E+4 (`SYNC_STAGES`=2).
- Read: address 8'h03, bench acks after 5 cycles with `reg_rdata`=8'h10 → `reg_re` high for 6 cycles; `spi_rdata`=8'h10 before `spi_ack_tgl` flips.
- Toggle flipped again while busy → the second request issues immediately after DONE; exactly two strobe pulses and two acknowledge flips.
- Timeout (macro on, `TIMEOUT_CYCLES`=8), read with no ack → strobe drops after 9 ISSUE cycles; `xfer_err`=1; `spi_rdata`=8'hFF; acknowledge toggles; `err_clr` then clears `xfer_err`.
- `wb_rstn_i` pulsed low during ISSUE → all outputs at reset values, no acknowledge flip; a new request afterwards completes normally.
